// File: rtl/lif_neuron_multi_pkg.sv
// Shared types and configuration-chain layout helpers for the LIF neuron.
package lif_pkg;

  typedef enum logic {
    INTEG  = 1'b0,
    REFRAC = 1'b1
  } lif_state_t;

  // Total configuration chain length: {w[N_SYN-1..0], thresh, leak_s, refrac}.
  function automatic int unsigned cfg_bits(input int unsigned w, input int unsigned n_syn,
                                           input int unsigned ls_w, input int unsigned ref_w);
    return n_syn * w + w + ls_w + ref_w;
  endfunction

  // Field offsets within the chain, LSB side first.
  localparam int unsigned REFRAC_LSB = 0;

  function automatic int unsigned leak_lsb(input int unsigned ref_w);
    return ref_w;
  endfunction

  function automatic int unsigned thresh_lsb(input int unsigned ls_w, input int unsigned ref_w);
    return ref_w + ls_w;
  endfunction

  function automatic int unsigned w0_lsb(input int unsigned w, input int unsigned ls_w,
                                         input int unsigned ref_w);
    return ref_w + ls_w + w;
  endfunction

endpackage

// File: rtl/lif_neuron_multi_if.sv
// Configuration, synapse and output signals of the LIF neuron.
interface lif_neuron_multi_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned N_SYN = 4
);
  logic             set_vars;
  logic             cfg_in;
  logic [N_SYN-1:0] syn;
  logic             axon;
  logic [W-1:0]     V;
  logic             refractory;

  modport master (output set_vars, output cfg_in, output syn,
                  input  axon, input V, input refractory);
  modport slave  (input  set_vars, input cfg_in, input syn,
                  output axon, output V, output refractory);
endinterface

// File: rtl/lif_neuron_multi_cfg_shift.sv
// Bit-serial configuration shift register, MSB-first, synchronous clear.
module lif_cfg_shift #(
  parameter int unsigned CFG_BITS = 47
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                en,
  input  logic                din,
  output logic [CFG_BITS-1:0] chain
);

  // Shift one bit in per enabled cycle; clear wipes any partial load.
  always_ff @(posedge clk) begin
    if (clr)     chain <= '0;
    else if (en) chain <= {chain[CFG_BITS-2:0], din};
  end

endmodule

// File: rtl/lif_neuron_multi.sv
// Multi-synapse leaky integrate-and-fire neuron with serial configuration.
module lif_neuron_multi
  import lif_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned N_SYN = 4,
  parameter int unsigned LS_W  = 3,
  parameter int unsigned REF_W = 4
) (
  input logic              clk,
  input logic              rst,
  lif_neuron_multi_if.slave bus
);

  localparam int unsigned CFG_BITS = cfg_bits(W, N_SYN, LS_W, REF_W);
  localparam int unsigned SUM_W    = W + $clog2(N_SYN);
  localparam int unsigned ACC_W    = SUM_W + 1;

  logic [CFG_BITS-1:0] cfg_vec;
  logic [W-1:0]        w [N_SYN];
  logic [W-1:0]        thresh;
  logic [LS_W-1:0]     leak_s;
  logic [REF_W-1:0]    refrac;

  lif_cfg_shift #(.CFG_BITS(CFG_BITS)) u_cfg (
    .clk   (clk),
    .clr   (rst),
    .en    (bus.set_vars),
    .din   (bus.cfg_in),
    .chain (cfg_vec)
  );

  assign refrac = cfg_vec[REFRAC_LSB +: REF_W];
  assign leak_s = cfg_vec[leak_lsb(REF_W) +: LS_W];
  assign thresh = cfg_vec[thresh_lsb(LS_W, REF_W) +: W];

  for (genvar g = 0; g < N_SYN; g++) begin : g_w
    assign w[g] = cfg_vec[w0_lsb(W, LS_W, REF_W) + g * W +: W];
  end

  lif_state_t       state_q, state_d;
  logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
  logic [W-1:0]     v_q, v_d;
  logic             axon_q, axon_d;

  logic [SUM_W-1:0] in_sum;
  logic [W-1:0]     shifted, leak;
  logic [ACC_W-1:0] acc_raw;
  logic [W-1:0]     acc;

  // Sum the weights of all synapses spiking this cycle, full width so nothing is lost.
  always_comb begin
    in_sum = '0;
    for (int unsigned i = 0; i < N_SYN; i++) begin
      if (bus.syn[i]) in_sum = in_sum + SUM_W'(w[i]);
    end
  end

  // Shift-based leak with a floor of 1 so V always decays to zero.
  always_comb begin
    shifted = v_q >> leak_s;
    if (leak_s == '0 || v_q == '0) leak = '0;
    else if (shifted == '0)        leak = W'(1);
    else                           leak = shifted;
    acc_raw = ACC_W'(v_q) - ACC_W'(leak) + ACC_W'(in_sum);
    acc     = (|acc_raw[ACC_W-1:W]) ? '1 : acc_raw[W-1:0];
  end

  // Next-state and output logic; config mode forces rest.
  always_comb begin
    state_d   = state_q;
    ref_cnt_d = ref_cnt_q;
    v_d       = v_q;
    axon_d    = 1'b0;
    if (bus.set_vars) begin
      state_d   = INTEG;
      ref_cnt_d = '0;
      v_d       = '0;
    end else begin
      unique case (state_q)
        INTEG: begin
          if (thresh != '0 && acc >= thresh) begin
            v_d    = '0;
            axon_d = 1'b1;
            if (refrac != '0) begin
              state_d   = REFRAC;
              ref_cnt_d = refrac;
            end
          end else begin
            v_d = acc;
          end
        end
        REFRAC: begin
          v_d = '0;
          if (ref_cnt_q == REF_W'(1)) begin
            state_d   = INTEG;
            ref_cnt_d = '0;
          end else begin
            ref_cnt_d = ref_cnt_q - REF_W'(1);
          end
        end
        default: state_d = INTEG;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INTEG;
      ref_cnt_q <= '0;
      v_q       <= '0;
      axon_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ref_cnt_q <= ref_cnt_d;
      v_q       <= v_d;
      axon_q    <= axon_d;
    end
  end

  assign bus.V          = v_q;
  assign bus.axon       = axon_q;
  assign bus.refractory = (state_q == REFRAC);

endmodule

// File: tb/tb_lif_neuron_multi.sv
// Randomised and directed bench for lif_neuron_multi against a cycle-level reference model.
module tb_lif_neuron_multi;
  import lif_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned LS = 3;
  localparam int unsigned RF = 4;
  localparam int unsigned CB = cfg_bits(W, N, LS, RF);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lif_neuron_multi_if #(.W(W), .N_SYN(N)) bus ();

  lif_neuron_multi #(.W(W), .N_SYN(N), .LS_W(LS), .REF_W(RF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model state: raw chain contents plus neuron behaviour.
  logic [CB-1:0] m_chain = '0;
  int            m_v     = 0;
  int            m_cnt   = 0;
  bit            m_axon  = 1'b0;
  bit            m_ref   = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic int fld(input int lsb, input int width);
    logic [CB-1:0] t;
    t = m_chain >> lsb;
    return int'(t[15:0]) & ((1 << width) - 1);
  endfunction

  function automatic void model_step(input bit r, input bit sv, input bit cin, input logic [3:0] s);
    int th, ls, rf, sum, lk, acc;
    if (r) begin
      m_chain = '0; m_v = 0; m_axon = 0; m_ref = 0; m_cnt = 0;
    end else if (sv) begin
      m_chain = {m_chain[CB-2:0], cin};
      m_v = 0; m_axon = 0; m_ref = 0; m_cnt = 0;
    end else if (m_ref) begin
      m_v = 0; m_axon = 0;
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) m_ref = 0;
    end else begin
      rf  = fld(0, RF);
      ls  = fld(RF, LS);
      th  = fld(RF + LS, W);
      sum = 0;
      for (int i = 0; i < N; i++)
        if (s[i]) sum += fld(RF + LS + W + i * W, W);
      if (ls == 0 || m_v == 0) lk = 0;
      else lk = (m_v / (1 << ls) > 0) ? m_v / (1 << ls) : 1;
      acc = m_v - lk + sum;
      if (acc > 255) acc = 255;
      if (th != 0 && acc >= th) begin
        m_v = 0; m_axon = 1;
        if (rf != 0) begin m_ref = 1; m_cnt = rf; end
      end else begin
        m_v = acc; m_axon = 0;
      end
    end
  endfunction

  task automatic cycle(input string tag, input bit r, input bit sv, input bit cin, input logic [3:0] s);
    rst          = r;
    bus.set_vars = sv;
    bus.cfg_in   = cin;
    bus.syn      = s;
    @(posedge clk);
    model_step(r, sv, cin, s);
    #1;
    check({tag, "_v"},    bus.V,          64'(m_v));
    check({tag, "_axon"}, bus.axon,       64'(m_axon));
    check({tag, "_ref"},  bus.refractory, 64'(m_ref));
  endtask

  task automatic load(input string tag, input int w3, input int w2, input int w1, input int w0,
                      input int th, input int ls, input int rf);
    logic [CB-1:0] vec;
    vec = (CB'(w3 & 255) << (RF + LS + W + 3 * W)) | (CB'(w2 & 255) << (RF + LS + W + 2 * W))
        | (CB'(w1 & 255) << (RF + LS + W + W))     | (CB'(w0 & 255) << (RF + LS + W))
        | (CB'(th & 255) << (RF + LS)) | (CB'(ls & 7) << RF) | CB'(rf & 15);
    for (int i = CB - 1; i >= 0; i--) cycle(tag, 1'b0, 1'b1, vec[i], 4'($urandom));
  endtask

  task automatic run(input string tag, input int n, input logic [3:0] s);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0, 1'b0, s);
  endtask

  initial begin
    bus.set_vars = 1'b0;
    bus.cfg_in   = 1'b0;
    bus.syn      = '0;

    // Reset after random activity, then all-zero weights keep V at 0.
    cycle("init", 1'b1, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 8; i++)
      cycle("pre_rst", 1'b0, 1'($urandom), 1'($urandom), 4'($urandom));
    cycle("rst", 1'b1, 1'b0, 1'b0, 4'hF);
    cycle("rst", 1'b1, 1'b1, 1'b1, 4'hF);
    check("rst_v_const", bus.V, 64'd0);
    run("zero_w", 4, 4'hF);
    check("zero_w_const", bus.V, 64'd0);

    // Integrate and fire with refractory period.
    load("if_load", 0, 0, 0, 10, 40, 0, 2);
    run("if_run", 3, 4'b0001);
    check("if_v30", bus.V, 64'd30);
    run("if_run", 1, 4'b0001);
    check("if_fire", bus.axon, 64'd1);
    run("if_run", 8, 4'b0001);

    // Leak decay down to zero.
    load("leak_load", 0, 0, 0, 100, 0, 1, 0);
    run("leak_run", 1, 4'b0001);
    check("leak_v100", bus.V, 64'd100);
    run("leak_run", 10, 4'b0000);
    check("leak_end", bus.V, 64'd0);

    // Two synapses summed in one cycle, no refractory.
    load("multi_load", 0, 0, 70, 60, 100, 0, 0);
    run("multi_run", 1, 4'b0011);
    check("multi_fire", bus.axon, 64'd1);
    run("multi_run", 3, 4'b0000);

    // Saturation with firing disabled.
    load("sat_load", 255, 255, 255, 255, 0, 0, 0);
    run("sat_run", 6, 4'b1111);
    check("sat_v", bus.V, 64'd255);

    // Config asserted mid-refractory, then full reload.
    load("mid_load", 0, 0, 0, 200, 100, 0, 15);
    run("mid_run", 4, 4'b0001);
    cycle("mid_cfg", 1'b0, 1'b1, 1'b0, 4'hF);
    check("mid_cfg_ref", bus.refractory, 64'd0);
    load("mid_reload", 0, 0, 0, 10, 40, 0, 2);
    run("mid_after", 6, 4'b0001);

    // Reset during a partial load clears the chain.
    for (int i = 0; i < 10; i++) cycle("part_load", 1'b0, 1'b1, 1'b1, 4'h0);
    cycle("part_rst", 1'b1, 1'b0, 1'b0, 4'h0);
    check("chain_clr", 64'(dut.cfg_vec), 64'd0);
    run("part_run", 4, 4'hF);

    // Randomised configurations and synapse traffic.
    for (int k = 0; k < 6; k++) begin
      load("rnd_load", int'($urandom_range(255)), int'($urandom_range(255)),
           int'($urandom_range(255)), int'($urandom_range(255)),
           int'($urandom_range(255)), int'($urandom_range(7)), int'($urandom_range(15)));
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(49) == 0) cycle("rnd_cfg", 1'b0, 1'b1, 1'($urandom), 4'($urandom));
        else                         cycle("rnd_run", 1'b0, 1'b0, 1'b0, 4'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
